// File: rtl/id_ex_stage_pkg.sv
// Shared PCPU definitions: control-bundle layout, encodings
// and the bubble constant used by the ID/EX boundary.
package id_ex_stage_pkg;

  localparam int ALUCTR_W = 4;
  localparam int BRANCH_W = 3;
  localparam int JUMP_W   = 2;
  localparam int MEMWR_W  = 2;
  localparam int MEMRD_W  = 2;
  localparam int FLAGS_W  = 8;
  localparam int REG_W    = 5;

  localparam logic [ALUCTR_W-1:0] ALU_ADDU = 4'd0;
  localparam logic [ALUCTR_W-1:0] ALU_SUBU = 4'd1;
  localparam logic [ALUCTR_W-1:0] ALU_AND  = 4'd2;
  localparam logic [ALUCTR_W-1:0] ALU_OR   = 4'd3;
  localparam logic [ALUCTR_W-1:0] ALU_SLT  = 4'd4;
  localparam logic [ALUCTR_W-1:0] ALU_SLL  = 4'd5;

  localparam logic [MEMRD_W-1:0] MR_NONE = 2'd0;
  localparam logic [MEMRD_W-1:0] MR_LW   = 2'd1;
  localparam logic [MEMRD_W-1:0] MR_LB   = 2'd2;
  localparam logic [MEMRD_W-1:0] MR_LBU  = 2'd3;

  localparam logic [MEMWR_W-1:0] MW_NONE = 2'd0;
  localparam logic [MEMWR_W-1:0] MW_SW   = 2'd1;
  localparam logic [MEMWR_W-1:0] MW_SB   = 2'd2;

  typedef struct packed {
    logic [ALUCTR_W-1:0] alu_ctr;
    logic [BRANCH_W-1:0] branch;
    logic [JUMP_W-1:0]   jump;
    logic [MEMWR_W-1:0]  mem_wr;
    logic [MEMRD_W-1:0]  mem_read;
    logic [FLAGS_W-1:0]  flags;
  } ctrl_t;

  localparam int    CTRL_W      = $bits(ctrl_t);
  localparam ctrl_t CTRL_BUBBLE = ctrl_t'({CTRL_W{1'b0}});

  function automatic logic is_load(input logic [MEMRD_W-1:0] mr);
    return mr != MR_NONE;
  endfunction

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use hazard check of the ID instruction
// against a load currently sitting in EX.
module load_use_detect
  import id_ex_stage_pkg::*;
(
  input  logic [MEMRD_W-1:0] ex_mem_read,
  input  logic [REG_W-1:0]   ex_rt,
  input  logic               ex_valid,
  input  logic [REG_W-1:0]   id_rs,
  input  logic [REG_W-1:0]   id_rt,
  input  logic               id_valid,
  output logic               load_use
);

  // $0 is never written, so a load targeting it cannot create a hazard
  assign load_use = ex_valid & is_load(ex_mem_read)
                  & (ex_rt != '0) & id_valid
                  & ((ex_rt == id_rs) | (ex_rt == id_rt));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion,
// flush/hold handling and a saturating bubble counter.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [ALUCTR_W-1:0] id_ALUctr,
  input  logic [BRANCH_W-1:0] id_Branch,
  input  logic [JUMP_W-1:0]   id_Jump,
  input  logic [MEMWR_W-1:0]  id_MemWr,
  input  logic [MEMRD_W-1:0]  id_MemRead,
  input  logic [FLAGS_W-1:0]  id_flags,
  input  logic [DATA_W-1:0]   id_pc4,
  input  logic [DATA_W-1:0]   id_busA,
  input  logic [DATA_W-1:0]   id_busB,
  input  logic [DATA_W-1:0]   id_imm,
  input  logic [REG_W-1:0]    id_rs,
  input  logic [REG_W-1:0]    id_rt,
  input  logic [REG_W-1:0]    id_rd,
  input  logic [REG_W-1:0]    id_shamt,
  input  logic                ex_flush,
  input  logic                ex_hold,
  output logic [ALUCTR_W-1:0] ex_ALUctr,
  output logic [BRANCH_W-1:0] ex_Branch,
  output logic [JUMP_W-1:0]   ex_Jump,
  output logic [MEMWR_W-1:0]  ex_MemWr,
  output logic [MEMRD_W-1:0]  ex_MemRead,
  output logic [FLAGS_W-1:0]  ex_flags,
  output logic [DATA_W-1:0]   ex_pc4,
  output logic [DATA_W-1:0]   ex_busA,
  output logic [DATA_W-1:0]   ex_busB,
  output logic [DATA_W-1:0]   ex_imm,
  output logic [REG_W-1:0]    ex_rs,
  output logic [REG_W-1:0]    ex_rt,
  output logic [REG_W-1:0]    ex_rd,
  output logic [REG_W-1:0]    ex_shamt,
  output logic                ex_valid,
  output logic                stall_if,
  output logic [CNT_W-1:0]    bubble_cnt
);

  ctrl_t id_ctrl;
  ctrl_t ex_ctrl;
  logic  load_use;
  logic  bubble;

  assign id_ctrl = '{alu_ctr:  id_ALUctr,
                     branch:   id_Branch,
                     jump:     id_Jump,
                     mem_wr:   id_MemWr,
                     mem_read: id_MemRead,
                     flags:    id_flags};

  assign ex_ALUctr  = ex_ctrl.alu_ctr;
  assign ex_Branch  = ex_ctrl.branch;
  assign ex_Jump    = ex_ctrl.jump;
  assign ex_MemWr   = ex_ctrl.mem_wr;
  assign ex_MemRead = ex_ctrl.mem_read;
  assign ex_flags   = ex_ctrl.flags;

  load_use_detect u_lud (
    .ex_mem_read (ex_ctrl.mem_read),
    .ex_rt       (ex_rt),
    .ex_valid    (ex_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_valid    (id_valid),
    .load_use    (load_use)
  );

  // A flush already kills the dependent instruction, so no IF stall
  assign stall_if = ~rst & (ex_hold | (load_use & ~ex_flush));
  assign bubble   = ex_flush | load_use;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_ctrl  <= CTRL_BUBBLE;
      ex_valid <= 1'b0;
      ex_pc4   <= '0;
      ex_busA  <= '0;
      ex_busB  <= '0;
      ex_imm   <= '0;
      ex_rs    <= '0;
      ex_rt    <= '0;
      ex_rd    <= '0;
      ex_shamt <= '0;
    end else if (!ex_hold) begin
      ex_ctrl  <= bubble ? CTRL_BUBBLE : id_ctrl;
      ex_valid <= bubble ? 1'b0 : id_valid;
      ex_pc4   <= id_pc4;
      ex_busA  <= id_busA;
      ex_busB  <= id_busB;
      ex_imm   <= id_imm;
      ex_rs    <= id_rs;
      ex_rt    <= id_rt;
      ex_rd    <= id_rd;
      ex_shamt <= id_shamt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (!ex_hold && bubble && id_valid
                 && bubble_cnt != {CNT_W{1'b1}}) begin
      bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: hazards, flush, hold,
// counter saturation and reset during a stall.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  localparam int DW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid;
  logic [3:0]    id_ALUctr;
  logic [2:0]    id_Branch;
  logic [1:0]    id_Jump;
  logic [1:0]    id_MemWr;
  logic [1:0]    id_MemRead;
  logic [7:0]    id_flags;
  logic [DW-1:0] id_pc4, id_busA, id_busB, id_imm;
  logic [4:0]    id_rs, id_rt, id_rd, id_shamt;
  logic          ex_flush, ex_hold;
  logic [3:0]    ex_ALUctr;
  logic [2:0]    ex_Branch;
  logic [1:0]    ex_Jump;
  logic [1:0]    ex_MemWr;
  logic [1:0]    ex_MemRead;
  logic [7:0]    ex_flags;
  logic [DW-1:0] ex_pc4, ex_busA, ex_busB, ex_imm;
  logic [4:0]    ex_rs, ex_rt, ex_rd, ex_shamt;
  logic          ex_valid, stall_if;
  logic [CW-1:0] bubble_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_ALUctr(id_ALUctr), .id_Branch(id_Branch),
    .id_Jump(id_Jump), .id_MemWr(id_MemWr),
    .id_MemRead(id_MemRead), .id_flags(id_flags),
    .id_pc4(id_pc4), .id_busA(id_busA), .id_busB(id_busB),
    .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_shamt(id_shamt),
    .ex_flush(ex_flush), .ex_hold(ex_hold),
    .ex_ALUctr(ex_ALUctr), .ex_Branch(ex_Branch),
    .ex_Jump(ex_Jump), .ex_MemWr(ex_MemWr),
    .ex_MemRead(ex_MemRead), .ex_flags(ex_flags),
    .ex_pc4(ex_pc4), .ex_busA(ex_busA), .ex_busB(ex_busB),
    .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_rd(ex_rd), .ex_shamt(ex_shamt),
    .ex_valid(ex_valid), .stall_if(stall_if),
    .bubble_cnt(bubble_cnt)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_id(input logic v, input logic [3:0] alu,
                        input logic [1:0] mr, input logic [1:0] mw,
                        input logic [7:0] fl, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd,
                        input logic [31:0] pc4);
    id_valid   = v;
    id_ALUctr  = alu;
    id_Branch  = 3'd0;
    id_Jump    = 2'd0;
    id_MemWr   = mw;
    id_MemRead = mr;
    id_flags   = fl;
    id_rs      = rs;
    id_rt      = rt;
    id_rd      = rd;
    id_shamt   = 5'd0;
    id_pc4     = pc4;
    id_busA    = pc4 ^ 32'hA5A5_0000;
    id_busB    = pc4 ^ 32'h0000_5A5A;
    id_imm     = {27'd0, rd};
  endtask

  // flag bytes: addu {RegDst,RegWr}, lw {ALUsrc,MemtoReg,RegWr,ExtOp},
  // sw {ALUsrc,ExtOp}
  localparam logic [7:0] F_ADDU = 8'h90;
  localparam logic [7:0] F_LW   = 8'h78;
  localparam logic [7:0] F_SW   = 8'h48;

  initial begin
    rst = 1'b1; ex_flush = 1'b0; ex_hold = 1'b0;
    set_id(1'b1, ALU_ADDU, MR_LW, MW_NONE, F_LW, 5'd1, 5'd1, 5'd0, 32'h40);
    settle();
    chk("rst_stall", stall_if, 1'b0);
    tick();
    chk("rst_valid", ex_valid, 1'b0);
    chk("rst_cnt", bubble_cnt, 16'd0);
    chk("rst_pc4", ex_pc4, 32'd0);
    chk("rst_flags", ex_flags, 8'd0);
    rst = 1'b0;

    // 1: lw $5 then addu $6,$5,$7
    set_id(1'b1, ALU_ADDU, MR_LW, MW_NONE, F_LW, 5'd2, 5'd5, 5'd0, 32'h104);
    tick();
    chk("t1_lw_valid", ex_valid, 1'b1);
    chk("t1_lw_rt", ex_rt, 5'd5);
    set_id(1'b1, ALU_ADDU, MR_NONE, MW_NONE, F_ADDU, 5'd5, 5'd7, 5'd6, 32'h108);
    settle();
    chk("t1_stall", stall_if, 1'b1);
    tick();
    chk("t1_bub_valid", ex_valid, 1'b0);
    chk("t1_bub_flags", ex_flags, 8'd0);
    chk("t1_bub_memrd", ex_MemRead, 2'd0);
    chk("t1_cnt", bubble_cnt, 16'd1);
    chk("t1_stall_off", stall_if, 1'b0);
    tick();
    chk("t1_add_valid", ex_valid, 1'b1);
    chk("t1_add_rd", ex_rd, 5'd6);
    chk("t1_add_flags", ex_flags, F_ADDU);
    chk("t1_add_pc4", ex_pc4, 32'h108);

    // 2: lw $0 then consumer of rs=0
    set_id(1'b1, ALU_ADDU, MR_LW, MW_NONE, F_LW, 5'd3, 5'd0, 5'd0, 32'h10C);
    tick();
    set_id(1'b1, ALU_OR, MR_NONE, MW_NONE, F_ADDU, 5'd0, 5'd3, 5'd4, 32'h110);
    settle();
    chk("t2_stall", stall_if, 1'b0);
    tick();
    chk("t2_valid", ex_valid, 1'b1);
    chk("t2_alu", ex_ALUctr, ALU_OR);
    chk("t2_cnt", bubble_cnt, 16'd1);

    // 3: flush kills a store
    set_id(1'b1, ALU_ADDU, MR_NONE, MW_SW, F_SW | 8'h10, 5'd1, 5'd2, 5'd0, 32'h114);
    ex_flush = 1'b1;
    settle();
    chk("t3_stall", stall_if, 1'b0);
    tick();
    ex_flush = 1'b0;
    chk("t3_valid", ex_valid, 1'b0);
    chk("t3_regwr", ex_flags[4], 1'b0);
    chk("t3_memwr", ex_MemWr, 2'd0);
    chk("t3_cnt", bubble_cnt, 16'd2);

    // 4: hold three cycles while ID changes (flush ignored under hold)
    set_id(1'b1, ALU_SUBU, MR_NONE, MW_NONE, F_ADDU, 5'd1, 5'd2, 5'd9, 32'h100);
    tick();
    chk("t4_load_rd", ex_rd, 5'd9);
    ex_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(1'b1, ALU_AND, MR_LW, MW_SW, F_LW, 5'd10 + 5'(i), 5'd11, 5'd12, 32'h200 + 32'(i));
      ex_flush = (i == 1);
      settle();
      chk("t4_stall", stall_if, 1'b1);
      tick();
      chk("t4_rd", ex_rd, 5'd9);
      chk("t4_pc4", ex_pc4, 32'h100);
      chk("t4_alu", ex_ALUctr, ALU_SUBU);
      chk("t4_valid", ex_valid, 1'b1);
      chk("t4_cnt", bubble_cnt, 16'd2);
    end
    ex_hold = 1'b0; ex_flush = 1'b0;

    // 5: load-use and flush together
    set_id(1'b1, ALU_ADDU, MR_LB, MW_NONE, F_LW, 5'd1, 5'd8, 5'd0, 32'h300);
    tick();
    set_id(1'b1, ALU_ADDU, MR_NONE, MW_NONE, F_ADDU, 5'd8, 5'd2, 5'd3, 32'h304);
    ex_flush = 1'b1;
    settle();
    chk("t5_stall", stall_if, 1'b0);
    tick();
    chk("t5_valid", ex_valid, 1'b0);
    chk("t5_cnt", bubble_cnt, 16'd3);
    id_valid = 1'b0;
    tick();
    chk("t5_nocount", bubble_cnt, 16'd3);

    // 6: saturate, then reset in the middle of a stall
    id_valid = 1'b1;
    for (int i = 0; i < 65532; i++) tick();
    chk("t6_full", bubble_cnt, 16'hFFFF);
    tick();
    chk("t6_sat", bubble_cnt, 16'hFFFF);
    ex_flush = 1'b0;
    set_id(1'b1, ALU_ADDU, MR_LBU, MW_NONE, F_LW, 5'd1, 5'd5, 5'd0, 32'h400);
    tick();
    set_id(1'b1, ALU_ADDU, MR_NONE, MW_NONE, F_ADDU, 5'd5, 5'd2, 5'd3, 32'h404);
    settle();
    chk("t6_stall", stall_if, 1'b1);
    rst = 1'b1;
    settle();
    chk("t6_rst_stall", stall_if, 1'b0);
    tick();
    chk("t6_rst_valid", ex_valid, 1'b0);
    chk("t6_rst_cnt", bubble_cnt, 16'd0);
    chk("t6_rst_memrd", ex_MemRead, 2'd0);
    chk("t6_rst_rt", ex_rt, 5'd0);
    chk("t6_rst_pc4", ex_pc4, 32'd0);
    chk("t6_rst_busa", ex_busA, 32'd0);
    rst = 1'b0;
    settle();
    chk("t6_after_stall", stall_if, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
